// File: rtl/counter_nbit_updn.sv
// Up/down counter over 0..MAX_VALUE with load clamping, optional saturation,
// and registered wrap/sat event pulses.
module counter_nbit_updn #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count_out,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] count_p0;
    logic             wrap_p0;
    logic             sat_p0;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_VALUE) ? MAX_VALUE : v;
    endfunction

    always_comb begin
        count_nxt = count_p0;
        wrap_nxt  = 1'b0;
        sat_nxt   = 1'b0;
        if (load) begin
            count_nxt = clamp_load(load_value);
        end else if (en) begin
            if (up_dn) begin
                if (count_p0 == MAX_VALUE) begin
                    // At the range end: either hold and flag, or roll over.
                    if (SATURATE) begin
                        sat_nxt = 1'b1;
                    end else begin
                        count_nxt = ZERO;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count_p0 + ONE;
                end
            end else begin
                if (count_p0 == ZERO) begin
                    if (SATURATE) begin
                        sat_nxt = 1'b1;
                    end else begin
                        count_nxt = MAX_VALUE;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count_p0 - ONE;
                end
            end
        end
    end

    // Stage p0: counter state and event pulses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_p0 <= ZERO;
            wrap_p0  <= 1'b0;
            sat_p0   <= 1'b0;
        end else begin
            count_p0 <= count_nxt;
            wrap_p0  <= wrap_nxt;
            sat_p0   <= sat_nxt;
        end
    end

    assign count_out = count_p0;
    assign at_max    = (count_p0 == MAX_VALUE);
    assign at_min    = (count_p0 == ZERO);
    assign wrap      = wrap_p0;
    assign sat       = SATURATE ? sat_p0 : 1'b0;

endmodule

// File: tb/tb_counter_nbit_updn.sv
// Directed bench: a default (wrapping) counter and a MAX_VALUE=999 saturating
// counter share one stimulus stream.
module tb_counter_nbit_updn;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load;
    logic [9:0] load_value;
    logic       en;
    logic       up_dn;

    logic [9:0] a_count, b_count;
    logic       a_at_max, a_at_min, a_wrap, a_sat;
    logic       b_at_max, b_at_min, b_wrap, b_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_nbit_updn u_dflt (
        .clk(clk), .rstn(rstn), .load(load), .load_value(load_value),
        .en(en), .up_dn(up_dn), .count_out(a_count), .at_max(a_at_max),
        .at_min(a_at_min), .wrap(a_wrap), .sat(a_sat)
    );

    counter_nbit_updn #(.WIDTH(10), .MAX_VALUE(10'd999), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rstn(rstn), .load(load), .load_value(load_value),
        .en(en), .up_dn(up_dn), .count_out(b_count), .at_max(b_at_max),
        .at_min(b_at_min), .wrap(b_wrap), .sat(b_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        int lv;
        int len;
        int exp_b;

        // Reset wins over load and en
        rstn = 1'b0; load = 1'b1; load_value = 10'd5; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("rst_cnt_a", a_count, 0);
        chk("rst_min_a", a_at_min, 1);
        chk("rst_max_a", a_at_max, 0);
        chk("rst_wrap_a", a_wrap, 0);
        chk("rst_cnt_b", b_count, 0);
        chk("rst_sat_b", b_sat, 0);

        // Load 1000 then count up 100 edges: 1100 mod 1024 = 76, one wrap
        rstn = 1'b1; load = 1'b1; load_value = 10'd1000;
        tick();
        chk("ld1000_a", a_count, 1000);
        chk("ld1000_clamp_b", b_count, 999);
        chk("ld1000_wrap_a", a_wrap, 0);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        wraps = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (a_wrap) wraps++;
        end
        chk("up100_cnt_a", a_count, 76);
        chk("up100_wraps_a", wraps, 1);
        chk("up100_sat_a", a_sat, 0);

        // Load 1023 then hold with en low
        load = 1'b1; load_value = 10'd1023;
        tick();
        chk("ld1023_max_a", a_at_max, 1);
        chk("ld1023_min_a", a_at_min, 0);
        load = 1'b0; en = 1'b0;
        tick();
        chk("hold_cnt_a", a_count, 1023);
        chk("hold_wrap_a", a_wrap, 0);

        // Load 2, count down: 1,0,1023,1022,1021 with wrap after 0->1023
        load = 1'b1; load_value = 10'd2; en = 1'b1;
        tick();
        load = 1'b0; up_dn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dn_cnt_a", a_count, (i == 0) ? 1 : (i == 1) ? 0 : (1025 - i));
            chk("dn_wrap_a", a_wrap, (i == 2) ? 1 : 0);
        end

        // Saturating instance: load 990, up 20 edges; blocked from edge 10 on
        load = 1'b1; load_value = 10'd990;
        tick();
        chk("ld990_b", b_count, 990);
        load = 1'b0; up_dn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_b = (990 + i > 999) ? 999 : 990 + i;
            chk("satup_cnt_b", b_count, exp_b);
            chk("satup_sat_b", b_sat, (i >= 10) ? 1 : 0);
            chk("satup_wrap_b", b_wrap, 0);
        end
        chk("satup_max_b", b_at_max, 1);
        chk("satup_cnt_a", a_count, 1010);
        en = 1'b0;
        tick();
        chk("sathold_cnt_b", b_count, 999);
        chk("sathold_sat_b", b_sat, 0);

        // Load with en high: clamped, no pulses
        load = 1'b1; load_value = 10'd1020; en = 1'b1;
        tick();
        chk("ld1020_b", b_count, 999);
        chk("ld1020_sat_b", b_sat, 0);
        chk("ld1020_wrap_b", b_wrap, 0);
        chk("ld1020_a", a_count, 1020);

        // Down at 0: wrap on default, saturate on second instance
        load_value = 10'd0;
        tick();
        load = 1'b0; up_dn = 1'b0;
        tick();
        chk("dn0_cnt_a", a_count, 1023);
        chk("dn0_wrap_a", a_wrap, 1);
        chk("dn0_cnt_b", b_count, 0);
        chk("dn0_sat_b", b_sat, 1);
        chk("dn0_min_b", b_at_min, 1);

        // Reset mid-count from 500, then resume from 0
        load = 1'b1; load_value = 10'd500;
        tick();
        load = 1'b0; up_dn = 1'b1;
        tick(); tick(); tick();
        chk("mid_cnt_a", a_count, 503);
        rstn = 1'b0; load = 1'b1; load_value = 10'd700;
        tick();
        chk("midrst_cnt_a", a_count, 0);
        chk("midrst_min_a", a_at_min, 1);
        rstn = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("resume_cnt_a", a_count, 1);

        // Random load values and up-count lengths
        for (int k = 0; k < 10; k++) begin
            lv  = int'($urandom_range(0, 1023));
            len = int'($urandom_range(100, 200));
            load = 1'b1; load_value = 10'(lv);
            tick();
            load = 1'b0; en = 1'b1; up_dn = 1'b1;
            repeat (len) tick();
            chk("rand_cnt_a", a_count, (lv + len) % 1024);
        end

        if (errors == 0) $display("TEST PASSED");
        else             $display("TEST FAILED");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_nbit_updn.md
COUNTER_NBIT_UPDN -- requirements
Module: counter_nbit_updn

Interface
REQ-001 SHALL provide parameter WIDTH, default 10, counter width in bits (legal 2..32).
REQ-002 SHALL provide parameter MAX_VALUE, default 2**WIDTH-1, terminal count; range is 0..MAX_VALUE (legal 1..2**WIDTH-1).
REQ-003 SHALL provide parameter SATURATE, default 0; 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port load  input  1  load load_value at next edge.
REQ-007 SHALL have port load_value  input  WIDTH  value to load.
REQ-008 SHALL have port en  input  1  count enable; tie high for free-running count.
REQ-009 SHALL have port up_dn  input  1  1 = count up, 0 = count down.
REQ-010 SHALL have port count_out  output  WIDTH  registered count.
REQ-011 SHALL have port at_max  output  1  combinational, high when count_out == MAX_VALUE.
REQ-012 SHALL have port at_min  output  1  combinational, high when count_out == 0.
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap.
REQ-014 SHALL have port sat  output  1  registered one-cycle pulse, high in the cycle after a blocked step (SATURATE=1 only).

Function
REQ-015 SHALL apply priority per edge: rstn low > load > en > hold.
REQ-016 SHALL, with load high, set count_out = load_value at that edge, with count_out first visible after the edge; en and up_dn ignored.
REQ-017 SHALL clamp any load_value > MAX_VALUE to MAX_VALUE; wrap and sat SHALL be 0 after a load.
REQ-018 SHALL, with load low and en high, step count_out by exactly 1 per edge in the up_dn direction.
REQ-019 SHALL, with load low and en low, hold count_out; wrap and sat SHALL be 0.
REQ-020 SHALL, for up at MAX_VALUE with SATURATE=0, go to 0 and pulse wrap; down at 0 SHALL go to MAX_VALUE and pulse wrap.
REQ-021 SHALL, for up at MAX_VALUE or down at 0 with SATURATE=1, hold the value and pulse sat; wrap SHALL stay 0.
REQ-022 SHALL tie sat constant 0 when SATURATE=0.
REQ-023 SHALL use no arithmetic wider than WIDTH+1 bits internally; count_out SHALL never exceed MAX_VALUE.
REQ-024 SHALL allow up_dn to change on any cycle; direction SHALL be sampled at the same edge as en.
REQ-025 SHALL, with WIDTH=10, MAX_VALUE=1023, SATURATE=0, en=1 and up_dn=1, give count_out = (loaded value + N) mod 1024 N edges after load deasserts.

Reset
REQ-026 SHALL, with rstn low at an edge, set count_out=0, wrap=0 and sat=0 regardless of load or en.
REQ-027 SHALL, on reset, set at_min=1 and at_max=0.
REQ-028 SHALL, on reset asserted mid-count, discard the count; counting SHALL resume from 0 at the first edge with rstn high and en high.
REQ-029 SHALL have no asynchronous reset path; rstn changes SHALL take effect only at clk rising edges.

Verification
REQ-030 SHALL cover default parameters, load 1000, up, en=1 for 100 edges -> count_out=76, wrap pulses exactly once (1023->0).
REQ-031 SHALL cover default parameters, load 2, up_dn=0 for 5 edges -> sequence 1,0,1023,1022,1021, with wrap pulsing after 0->1023.
REQ-032 SHALL cover MAX_VALUE=999, SATURATE=1, load 990, up 20 edges -> count_out holds 999, at_max=1, sat pulses on each of the last 11 edges, wrap stays 0.
REQ-033 SHALL cover load=1 with en=1, load_value=1020, MAX_VALUE=999 -> count_out=999 (clamped), no wrap or sat.
REQ-034 SHALL cover counting from 500, rstn low for 1 edge with load=1 -> count_out=0 and at_min=1; first edge after release with en=1 -> count_out=1.
REQ-035 SHALL cover 10 random load values and random 100..200 up-count lengths, default parameters -> count_out == (value+len) mod 1024 each time, and the bench SHALL print TEST PASSED or TEST FAILED.
